four_bit_counter: RTL and testbench

// - Enable-gated binary up-counter, 4 bits by default.
// - Advances by one on each rising clock edge while the count enable is high.
// - Wraps from the maximum value back to zero.
// - Used as a small cycle/step counter in the cellular-automaton display datapath.
//   Its output feeds generation/step logic and display logic.
//

---
 rtl/four_bit_counter.sv | 42 ++++
 tb/tb_four_bit_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/four_bit_counter.sv
// Enable-gated modulo (MAX_VAL+1) up-counter used as a step/generation
// counter in the cellular-automaton display datapath. Active-low
// asynchronous reset; out comes straight from the state register.
module four_bit_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] TermVal = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: advance on enable, wrapping to zero at the terminal value.
  always_comb begin
    count_d = count_q;
    if (count) begin
      if (count_q == TermVal) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State register; reset clears immediately and dominates the enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: tb/tb_four_bit_counter.sv
// Directed, table-driven bench for four_bit_counter (WIDTH=4, MAX_VAL=15).
module tb_four_bit_counter;

  logic       clk;
  logic       reset;
  logic       count;
  logic [3:0] out;

  int unsigned checks;
  int unsigned errors;

  typedef struct {
    logic       rst;
    logic       cnt;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  four_bit_counter #(
    .WIDTH   (4),
    .MAX_VAL (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic c, input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.cnt = c;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: out=%0d expected=%0d", name, out, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Power-up: reset held one cycle, then idle two edges.
    add(1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b0, 4'd0);
    // Basic count: 2 up, hold, 4 up.
    add(1'b1, 1'b1, 4'd1);
    add(1'b1, 1'b1, 4'd2);
    add(1'b1, 1'b0, 4'd2);
    add(1'b1, 1'b1, 4'd3);
    add(1'b1, 1'b1, 4'd4);
    add(1'b1, 1'b1, 4'd5);
    add(1'b1, 1'b1, 4'd6);
    // Toggled enable 0,0,1,0,1 from 6.
    add(1'b1, 1'b0, 4'd6);
    add(1'b1, 1'b0, 4'd6);
    add(1'b1, 1'b1, 4'd7);
    add(1'b1, 1'b0, 4'd7);
    add(1'b1, 1'b1, 4'd8);
    // Wrap: reset, 15 increments to 15, then 0, 1, 2.
    add(1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 15; i++) add(1'b1, 1'b1, 4'(i));
    add(1'b1, 1'b1, 4'd0);
    add(1'b1, 1'b1, 4'd1);
    add(1'b1, 1'b1, 4'd2);
    // Hold stability: reset, count to 5, then 12 idle edges.
    add(1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 5; i++) add(1'b1, 1'b1, 4'(i));
    for (int i = 0; i < 12; i++) add(1'b1, 1'b0, 4'd5);

    // Reset is asynchronous: out must be 0 before the first clock edge.
    reset = 1'b0;
    count = 1'b0;
    #1;
    check("async_reset_at_powerup", 4'd0);

    // Inputs change on the falling edge, out is sampled 1 after the rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      count = vecs[i].cnt;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), vecs[i].exp);
    end

    // Async reset mid-count: reset, count up to 9 with enable held high.
    @(negedge clk);
    reset = 1'b0;
    count = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1;
    check("midcount_reach_9", 4'd9);
    // Drop reset midway between edges: out clears without a clock edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midcount_async_clear", 4'd0);
    // Held in reset across two edges, enable high then unknown.
    @(posedge clk);
    #1;
    check("midcount_hold_reset_1", 4'd0);
    @(negedge clk);
    count = 1'bx;
    @(posedge clk);
    #1;
    check("midcount_hold_reset_x", 4'd0);
    // Release and resume from 0.
    @(negedge clk);
    count = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midcount_resume", 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
